fft_out_reorder: RTL
====================

Name: fft_out_reorder

Overview:
- Output reorder buffer directly downstream of the 4-lane parallel FFT core (30-bit complex outputs: 15-bit real, 15-bit imag, real in the upper half).
- Core emits each N-point frame in bit-reversed order, 4 samples per cycle. This block converts it to natural bin order at the same throughput.
- Ping-pong register banks let one frame be written while the previous one is read out.

Parameters:
- NB, 15, bits per real/imag component; sample width is 2*NB.
- N, 32, points per frame; power of 2, at least 8.
- P, 4, lanes per cycle (fixed at 4); a frame takes N/P beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat qualifier.
- in_start  in  1  first beat of a frame; only meaningful when in_valid=1.
- in0_up  in  2*NB  lane 0.
- in0_down  in  2*NB  lane 1.
- in1_up  in  2*NB  lane 2.
- in1_down  in  2*NB  lane 3.
- out0_up  out  2*NB  natural-order lane 0.
- out0_down  out  2*NB  natural-order lane 1.
- out1_up  out  2*NB  natural-order lane 2.
- out1_down  out  2*NB  natural-order lane 3.
- out_valid  out  1  output beat qualifier.
- out_start  out  1  first output beat of a frame.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (rst=0, async): all outputs 0; write count 0; write bank 0; reader idle; bank contents don't-care.
- Write index:
  - On a valid beat c of a frame (c = 0..N/P-1), lane l carries arrival index k = c*P + l.
  - That sample is stored at bin bitrev_log2(N)(k) of the current write bank.
  - Example, N=32, beat 0: lanes carry bins 0, 16, 8, 24.
- Framing:
  - in_valid=1 with in_start=1 forces c=0.
  - in_valid=0 beats are ignored: no write, no count advance.
  - Gaps inside a frame are allowed.
- Mid-frame restart: if in_start arrives while c≠0:
  - frame_err pulses the next cycle;
  - the partial frame is discarded;
  - writing restarts at c=0 in the same bank with the current beat.
- Stray data: a beat with in_valid=1, in_start=0 while c=0 and no frame is open is dropped. The block waits for in_start.
- Frame completion: after the write at c=N/P-1:
  - the bank is marked full;
  - the write bank toggles;
  - c returns to 0, and the block then requires in_start again.
- Read FSM states:
  - IDLE to READ when a full bank exists.
  - In READ, read beat r = 0..N/P-1 outputs bins r*P+0..3 on out0_up, out0_down, out1_up, out1_down.
  - out_valid=1 for N/P consecutive cycles; out_start=1 on r=0 only.
  - After r=N/P-1: return to IDLE, or stay in READ with r=0 if the other bank is already full.
  - Reads are never stalled (no backpressure).
- Latency: the first output beat is registered 1 cycle after the clock edge that writes the frame's last beat. With continuous input, output is continuous with a 1-frame-plus-1-cycle delay.
- Collision: none by construction. Reading a bank takes exactly N/P cycles, and writing the other bank takes at least N/P cycles.
- Outputs:
  - Data outputs are registered.
  - When out_valid=0, data outputs hold their last value, and out_start=0.
- Arithmetic: none; samples are passed bit-exact.
- Reset mid-frame or mid-read: everything returns to the reset state immediately; in-flight frames are lost.

Test Plan:
- Ramp frame: N=32, continuous in_valid, in_start on beat 0, each lane carrying value = its bitrev bin (beat 0 = 0, 16, 8, 24) → from 1 cycle after the last write, 8 out_valid beats; beat r outputs 4r..4r+3; out_start only on r=0.
- Back-to-back: 3 consecutive frames with distinct offsets (+0, +100, +200) → 24 contiguous out_valid cycles in the correct order, no gap between frames.
- Gapped input: in_valid toggled 1/0 within a frame → output values identical to the ramp case; output still 8 contiguous cycles.
- Mid-frame restart: in_start reasserted at beat 5, then a full frame follows → frame_err pulses once; only the full frame is emitted.
- Stray data: beats with in_valid=1, in_start=0 after reset → out_valid stays 0 and nothing is stored.
- Async reset: rst pulled low during read beat 3 → all outputs 0 immediately; the next frame after reset reorders correctly.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Sample bus between the 4-lane FFT core and the natural-order reorder buffer.
// Lanes: in0_up/in0_down/in1_up/in1_down map to lanes 0..3. Same mapping on the output side.
interface fft_out_reorder_if #(
    parameter int NB = 15
);
    localparam int W = 2 * NB;

    logic         in_valid;
    logic         in_start;
    logic [W-1:0] in0_up;
    logic [W-1:0] in0_down;
    logic [W-1:0] in1_up;
    logic [W-1:0] in1_down;
    logic [W-1:0] out0_up;
    logic [W-1:0] out0_down;
    logic [W-1:0] out1_up;
    logic [W-1:0] out1_down;
    logic         out_valid;
    logic         out_start;
    logic         frame_err;

    modport master (
        output in_valid, in_start, in0_up, in0_down, in1_up, in1_down,
        input  out0_up, out0_down, out1_up, out1_down, out_valid, out_start, frame_err
    );

    modport slave (
        input  in_valid, in_start, in0_up, in0_down, in1_up, in1_down,
        output out0_up, out0_down, out1_up, out1_down, out_valid, out_start, frame_err
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT frames at their natural bin and reads
// them back 4 bins per cycle, one frame behind the writer.
module fft_out_reorder #(
    parameter int NB = 15,
    parameter int N  = 32,
    parameter int P  = 4
) (
    input logic             clk,
    input logic             rst,
    fft_out_reorder_if.slave bus
);
    localparam int W     = 2 * NB;
    localparam int LOGN  = $clog2(N);
    localparam int BEATS = N / P;
    localparam int CW    = $clog2(BEATS);

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] k);
        for (int i = 0; i < LOGN; i++) bitrev[i] = k[LOGN-1-i];
    endfunction

    logic [P-1:0][W-1:0] lane_in;
    logic [P-1:0][W-1:0] out_q;
    logic [W-1:0]        mem [2][N];

    logic [CW-1:0] wcnt, wbeat, rcnt, rbeat;
    logic          open, wbank, rbank;
    logic [1:0]    full;
    logic          wr_en, wr_last, rd_last;
    logic          out_valid_q, out_start_q, frame_err_q;
    state_t        state;

    assign lane_in = {bus.in1_down, bus.in1_up, bus.in0_down, bus.in0_up};

    always_comb begin
        wr_en   = bus.in_valid && (bus.in_start || open);
        wbeat   = bus.in_start ? '0 : wcnt;
        wr_last = wr_en && !bus.in_start && (wcnt == CW'(BEATS - 1));
        rd_last = (state == READ) && (rcnt == CW'(BEATS - 1));
        rbeat   = (state == IDLE) ? '0 : rcnt;
    end

    // Bank storage carries no reset; its contents are only ever read after a full write.
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int l = 0; l < P; l++)
                mem[wbank][bitrev({wbeat, 2'(l)})] <= lane_in[l];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt        <= '0;
            open        <= 1'b0;
            wbank       <= 1'b0;
            full        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            // in_start on an open frame abandons it and restarts in the same bank
            frame_err_q <= bus.in_valid && bus.in_start && open;
            if (wr_en) begin
                if (wr_last) begin
                    wcnt  <= '0;
                    open  <= 1'b0;
                    wbank <= ~wbank;
                end else begin
                    wcnt <= wbeat + 1'b1;
                    open <= 1'b1;
                end
            end
            for (int b = 0; b < 2; b++)
                full[b] <= (full[b] | (wr_last && wbank == 1'(b)))
                         & ~(rd_last && rbank == 1'(b));
        end
    end

    // Reader: IDLE emits beat 0 on the cycle it sees a full bank, so output starts one edge after the last write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rcnt        <= '0;
            rbank       <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            if ((state == READ) || full[rbank]) begin
                out_valid_q <= 1'b1;
                out_start_q <= (rbeat == '0);
                for (int l = 0; l < P; l++)
                    out_q[l] <= mem[rbank][{rbeat, 2'(l)}];
            end
            case (state)
                IDLE: if (full[rbank]) begin
                    state <= READ;
                    rcnt  <= CW'(1);
                end
                READ: begin
                    rcnt <= rcnt + 1'b1;
                    if (rd_last) begin
                        rbank <= ~rbank;
                        rcnt  <= '0;
                        state <= full[~rbank] ? READ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out0_up   = out_q[0];
    assign bus.out0_down = out_q[1];
    assign bus.out1_up   = out_q[2];
    assign bus.out1_down = out_q[3];
    assign bus.out_valid = out_valid_q;
    assign bus.out_start = out_start_q;
    assign bus.frame_err = frame_err_q;
endmodule
